// File: rtl/id_freelist.sv
// id_freelist: lowest-first tag allocator with a free mask, one-hot release and double-free detection
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset (all tags free)
//   alloc_val       at least one tag is allocatable this cycle
//   alloc_id        lowest free tag (0 when none)
//   alloc_en        consumer takes alloc_id this cycle (ignored when alloc_val=0)
//   free_en/free_id return tag free_id
//   num_free        popcount of the free mask register
//   err_double_free registered pulse after a free of an already-free or out-of-range tag
// Build option ID_FREELIST_BYPASS_EN: with an empty mask, a tag being freed is offered
// to alloc in the same cycle.
module id_freelist #(
  parameter int p_num_ids = 8,
  parameter int p_id_bits = $clog2(p_num_ids)
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           alloc_val,
  output logic [p_id_bits-1:0]           alloc_id,
  input  logic                           alloc_en,
  input  logic                           free_en,
  input  logic [p_id_bits-1:0]           free_id,
  output logic [$clog2(p_num_ids+1)-1:0] num_free,
  output logic                           err_double_free
);
  localparam int p_cnt_bits = $clog2(p_num_ids + 1);
  logic [p_num_ids-1:0] free_mask, free_oh, alloc_oh;
  logic [p_id_bits-1:0] enc_id;
  logic                 mask_any, in_range, free_hit, free_ok, alloc_fire;
  always_comb begin
    enc_id = '0;
    for (int i = p_num_ids - 1; i >= 0; i--)
      if (free_mask[i]) enc_id = p_id_bits'(i);
  end
  assign mask_any = |free_mask;
  assign in_range = {{(32 - p_id_bits){1'b0}}, free_id} < p_num_ids;
  assign free_oh  = in_range ? (p_num_ids'(1) << free_id) : '0;
  // a set bit already in the mask means the tag is free: releasing it again is an error,
  // even when the same tag is being allocated this cycle
  assign free_hit = |(free_oh & free_mask);
  assign free_ok  = free_en && in_range && !free_hit;
`ifdef ID_FREELIST_BYPASS_EN
  assign alloc_val = mask_any ? 1'b1 : (free_en && in_range);
  assign alloc_id  = mask_any ? enc_id : free_id;
`else
  assign alloc_val = mask_any;
  assign alloc_id  = enc_id;
`endif
  assign alloc_fire = alloc_en && alloc_val;
  assign alloc_oh   = alloc_fire ? (p_num_ids'(1) << alloc_id) : '0;
  // set before clear so a bypassed tag (freed and taken together) leaves its bit clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      free_mask       <= '1;
      num_free        <= p_cnt_bits'(p_num_ids);
      err_double_free <= 1'b0;
    end else begin
      free_mask       <= (free_mask | (free_ok ? free_oh : '0)) & ~alloc_oh;
      num_free        <= num_free + p_cnt_bits'(free_ok) - p_cnt_bits'(alloc_fire);
      err_double_free <= free_en && !free_ok;
    end
endmodule

// File: tb/tb_id_freelist.sv
// tb_id_freelist: directed checks of allocation order, release, double free, empty-mask free and async reset
module tb_id_freelist;
  logic       clk = 1'b0;
  logic       rst, alloc_en, free_en;
  logic [2:0] free_id, alloc_id;
  logic       alloc_val, err_double_free;
  logic [3:0] num_free;
  int total = 0;
  int bad = 0;

  id_freelist #(.p_num_ids(8)) dut (
    .clk(clk), .rst(rst), .alloc_val(alloc_val), .alloc_id(alloc_id),
    .alloc_en(alloc_en), .free_en(free_en), .free_id(free_id),
    .num_free(num_free), .err_double_free(err_double_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic free_one(input int id);
    free_en = 1'b1;
    free_id = 3'(id);
    tick();
    free_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alloc_en = 1'b0; free_en = 1'b0; free_id = '0;
    #1;
    chk("rst_num_free", int'(num_free), 8);
    chk("rst_err", int'(err_double_free), 0);
    chk("rst_alloc_val", int'(alloc_val), 1);
    chk("rst_alloc_id", int'(alloc_id), 0);
    tick();
    rst = 1'b0;
    // drain in ascending order
    alloc_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_val", int'(alloc_val), 1);
      chk("drain_id", int'(alloc_id), i);
      tick();
    end
    chk("empty_val", int'(alloc_val), 0);
    chk("empty_num", int'(num_free), 0);
    chk("empty_id", int'(alloc_id), 0);
    tick();
    chk("empty_alloc_ignored_num", int'(num_free), 0);
    chk("empty_alloc_ignored_err", int'(err_double_free), 0);
    alloc_en = 1'b0;
    // release order and lowest-wins
    free_one(5);
    chk("free5_val", int'(alloc_val), 1);
    chk("free5_id", int'(alloc_id), 5);
    chk("free5_num", int'(num_free), 1);
    chk("free5_err", int'(err_double_free), 0);
    free_one(2);
    chk("free2_id", int'(alloc_id), 2);
    chk("free2_num", int'(num_free), 2);
    alloc_en = 1'b1;
    tick();
    chk("take2_next_id", int'(alloc_id), 5);
    tick();
    alloc_en = 1'b0;
    chk("redrain_val", int'(alloc_val), 0);
    // build mask 0b11110000
    for (int i = 4; i < 8; i++) free_one(i);
    chk("f0_num", int'(num_free), 4);
    alloc_en = 1'b1; free_en = 1'b1; free_id = 3'd1;
    #1;
    chk("simul_id", int'(alloc_id), 4);
    tick();
    alloc_en = 1'b0; free_en = 1'b0;
    chk("simul_next_id", int'(alloc_id), 1);
    chk("simul_num", int'(num_free), 4);
    chk("simul_err", int'(err_double_free), 0);
    // mask 0b11100010: free 3 legally, then again
    free_one(3);
    chk("free3_num", int'(num_free), 5);
    chk("free3_err", int'(err_double_free), 0);
    free_one(3);
    chk("dbl_err", int'(err_double_free), 1);
    chk("dbl_num", int'(num_free), 5);
    tick();
    chk("dbl_err_pulse", int'(err_double_free), 0);
    chk("dbl_num_hold", int'(num_free), 5);
    // double free racing alloc of the same tag (1)
    alloc_en = 1'b1; free_en = 1'b1; free_id = 3'd1;
    #1;
    chk("race_id", int'(alloc_id), 1);
    tick();
    alloc_en = 1'b0; free_en = 1'b0;
    chk("race_err", int'(err_double_free), 1);
    chk("race_num", int'(num_free), 4);
    chk("race_next_id", int'(alloc_id), 3);
    // mask {3,5,6,7}: drain, then free 6 with alloc on an empty mask
    alloc_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drain2_num", int'(num_free), 0);
    free_en = 1'b1; free_id = 3'd6;
    #1;
`ifdef ID_FREELIST_BYPASS_EN
    chk("bypass_val", int'(alloc_val), 1);
    chk("bypass_id", int'(alloc_id), 6);
    tick();
    alloc_en = 1'b0; free_en = 1'b0;
    chk("bypass_num", int'(num_free), 0);
    chk("bypass_next_val", int'(alloc_val), 0);
    chk("bypass_err", int'(err_double_free), 0);
`else
    chk("nobypass_val", int'(alloc_val), 0);
    tick();
    alloc_en = 1'b0; free_en = 1'b0;
    chk("nobypass_next_val", int'(alloc_val), 1);
    chk("nobypass_next_id", int'(alloc_id), 6);
    chk("nobypass_num", int'(num_free), 1);
    chk("nobypass_err", int'(err_double_free), 0);
`endif
    // clean reset, allocate 3, then asynchronous reset between edges
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alloc_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    alloc_en = 1'b0;
    chk("pre_rst_num", int'(num_free), 5);
    chk("pre_rst_id", int'(alloc_id), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_num", int'(num_free), 8);
    chk("async_rst_id", int'(alloc_id), 0);
    alloc_en = 1'b1; free_en = 1'b1; free_id = 3'd2;
    tick();
    rst = 1'b0; alloc_en = 1'b0; free_en = 1'b0;
    #1;
    chk("rst_ignores_num", int'(num_free), 8);
    chk("rst_ignores_err", int'(err_double_free), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
